// File: rtl/perf_ctrl.sv
// perf_ctrl: MMIO-controlled performance counter block.
// Counts cycles and retired instructions while running, with an optional
// cycle limit that auto-stops the run and saturating counters.
// Optional feature macro: PERF_BRANCH_STATS_EN adds branch total and
// branch mispredict counters at offsets 4 and 5. Without it those
// offsets read 0 and no branch counter flops exist.
//
// Register map (word offsets):
//   0 CTRL (write: bit0 START, bit1 STOP, bit2 CLEAR) / STATUS (read: bit0 running, bit1 done)
//   1 CYCLE, 2 INSTR, 3 LIMIT (r/w), 4 BR_TOTAL, 5 BR_MISPRED, 6-7 read 0
module perf_ctrl #(
   parameter int               CNT_W     = 32,
   parameter logic [CNT_W-1:0] LIMIT_RST = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mmio_en,
   input  logic             mmio_we,
   input  logic [2:0]       mmio_addr,
   input  logic [CNT_W-1:0] mmio_wdata,
   output logic [CNT_W-1:0] mmio_rdata,
   input  logic             inst_retire,
   input  logic             br_resolve,
   input  logic             br_mispred,
   output logic             running,
   output logic             done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Event counters share one implementation: slot 0 is INSTR, slots 1/2
   // are BR_TOTAL/BR_MISPRED when branch statistics are built in.
`ifdef PERF_BRANCH_STATS_EN
   localparam int NUM_EV = 3;
`else
   localparam int NUM_EV = 1;
`endif

   logic [1:0]              state_reg, state_next;
   logic [CNT_W-1:0]        cycle_reg, cycle_next;
   logic [CNT_W-1:0]        cycle_inc;
   logic [CNT_W-1:0]        limit_reg;
   logic [CNT_W-1:0]        rdata_reg;
   logic [CNT_W-1:0]        rd_val;
   logic                    running_reg, done_reg;
   logic                    in_run;
   logic                    limit_hit;
   logic                    ctrl_wr, limit_wr, rd_en;
   logic                    cmd_clear, cmd_start, cmd_stop;
   logic [NUM_EV-1:0]       ev_hit;
   logic [NUM_EV*CNT_W-1:0] ev_flat;

   assign ctrl_wr   = mmio_en & mmio_we & (mmio_addr == 3'd0);
   assign limit_wr  = mmio_en & mmio_we & (mmio_addr == 3'd3);
   assign rd_en     = mmio_en & ~mmio_we;
   assign cmd_clear = ctrl_wr & mmio_wdata[2];
   assign cmd_start = ctrl_wr & mmio_wdata[0];
   assign cmd_stop  = ctrl_wr & mmio_wdata[1];

   assign in_run    = (state_reg == ST_RUN);
   assign cycle_inc = (cycle_reg == CNT_MAX) ? cycle_reg : cycle_reg + CNT_ONE;
   // A limit already passed (LIMIT lowered mid-run) also ends the run.
   assign limit_hit = in_run && (limit_reg != '0) && (cycle_inc >= limit_reg);

   assign ev_hit[0] = inst_retire;
`ifdef PERF_BRANCH_STATS_EN
   assign ev_hit[1] = br_resolve;
   assign ev_hit[2] = br_resolve & br_mispred;
`else
   logic unused_br;
   assign unused_br = br_resolve ^ br_mispred;
`endif

   // Next state and cycle count: run-time counting/auto-stop, then commands
   // in priority CLEAR > START > STOP.
   always_comb begin
      state_next = state_reg;
      cycle_next = cycle_reg;
      if (in_run) begin
         if (limit_hit) begin
            cycle_next = (cycle_reg < limit_reg) ? limit_reg : cycle_reg;
            state_next = ST_DONE;
         end else begin
            cycle_next = cycle_inc;
         end
      end
      if (cmd_clear) begin
         state_next = ST_IDLE;
         cycle_next = '0;
      end else if (cmd_start) begin
         if (state_reg != ST_RUN) begin
            state_next = ST_RUN;
         end
      end else if (cmd_stop) begin
         if (in_run) begin
            state_next = ST_IDLE;
         end
      end
   end

   // Saturating event counters, one per event slot.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_EV; gi++) begin : g_ev
         logic [CNT_W-1:0] cnt_reg;
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg <= '0;
            end else if (cmd_clear) begin
               cnt_reg <= '0;
            end else if (in_run && ev_hit[gi] && (cnt_reg != CNT_MAX)) begin
               cnt_reg <= cnt_reg + CNT_ONE;
            end
         end
         assign ev_flat[gi*CNT_W +: CNT_W] = cnt_reg;
      end
   endgenerate

   // Read mux over pre-update register values.
   always_comb begin
      rd_val = '0;
      case (mmio_addr)
         3'd0: begin
            rd_val[0] = running_reg;
            rd_val[1] = done_reg;
         end
         3'd1: rd_val = cycle_reg;
         3'd2: rd_val = ev_flat[0 +: CNT_W];
         3'd3: rd_val = limit_reg;
`ifdef PERF_BRANCH_STATS_EN
         3'd4: rd_val = ev_flat[CNT_W +: CNT_W];
         3'd5: rd_val = ev_flat[2*CNT_W +: CNT_W];
`endif
         default: rd_val = '0;
      endcase
   end

   // FSM, cycle counter, LIMIT, read data and status flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         cycle_reg   <= '0;
         limit_reg   <= LIMIT_RST;
         rdata_reg   <= '0;
         running_reg <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cycle_reg   <= cycle_next;
         if (limit_wr) begin
            limit_reg <= mmio_wdata;
         end
         if (rd_en) begin
            rdata_reg <= rd_val;
         end
         running_reg <= (state_next == ST_RUN);
         done_reg    <= (state_next == ST_DONE);
      end
   end

   assign mmio_rdata = rdata_reg;
   assign running    = running_reg;
   assign done       = done_reg;

endmodule
